// File: rtl/button_debouncer.sv
// Multi-channel push-button conditioner: polarity fix, 2-FF synchroniser, and a per-channel
// debounce FSM producing a clean level plus press, release and long-press pulses.
module button_debouncer #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned CNT_W           = 32,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  typedef enum logic [1:0] {
    StReleased,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  localparam logic [CNT_W-1:0] DebLimit  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LongLimit = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  logic [N_BTN-1:0] pin_pressed;
  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;

  // Normalise polarity before the synchroniser so every later stage sees 1 = pressed.
  assign pin_pressed = btn_in ^ {N_BTN{ACTIVE_LOW}};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pin_pressed;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             s;

    assign s = sync2_q[i];

    // State register, counters and registered outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= StReleased;
        cnt_q     <= '0;
        hold_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        hold_q    <= hold_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
      end
    end

    // Next-state and counter logic.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      unique case (state_q)
        StReleased: begin
          if (s) begin
            state_d = StPressWait;
            cnt_d   = CntOne;
          end
        end
        StPressWait: begin
          if (!s) begin
            state_d = StReleased;
          end else if (cnt_q == DebLimit) begin
            state_d = StPressed;
            hold_d  = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StPressed: begin
          if (!s) begin
            state_d = StReleaseWait;
            cnt_d   = CntOne;
          end else if (hold_q < LongLimit) begin
            hold_d = hold_q + CntOne;
          end
        end
        StReleaseWait: begin
          // A bounce back to pressed keeps hold, so the long pulse cannot re-fire.
          if (s) begin
            state_d = StPressed;
          end else if (cnt_q == DebLimit) begin
            state_d = StReleased;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = StReleased;
        end
      endcase
    end

    // Output decode: pulses fire on the accepting transition, level follows them.
    always_comb begin
      press_d   = (state_q == StPressWait) && s && (cnt_q == DebLimit);
      release_d = (state_q == StReleaseWait) && !s && (cnt_q == DebLimit);
      long_d    = (state_q == StPressed) && s && (hold_q < LongLimit) &&
                  (hold_q + CntOne == LongLimit);
      level_d   = level_q;
      if (press_d) begin
        level_d = 1'b1;
      end else if (release_d) begin
        level_d = 1'b0;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_long[i]    = long_q;
  end

endmodule
